// File: rtl/cpu_run_controller_if.sv
// Signal bundle between the run controller and its user (bench or bring-up logic).
// The controller takes the master modport; the user side takes the slave modport.
interface cpu_run_controller_if #(
  parameter int CNT_W = 32,
  parameter int PC_W  = 32
);
  logic             start;
  logic             cpu_halt;
  logic [PC_W-1:0]  cpu_pc;
  logic             cpu_reset_n;
  logic             running;
  logic             done;
  logic             timeout;
  logic             stalled;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    input  start, cpu_halt, cpu_pc,
    output cpu_reset_n, running, done, timeout, stalled, cycle_count
  );

  modport slave (
    output start, cpu_halt, cpu_pc,
    input  cpu_reset_n, running, done, timeout, stalled, cycle_count
  );
endinterface

// File: rtl/cpu_run_controller.sv
// Run controller for the MIYAJIRO core: reset sequencing, cycle counting, halt/limit stop.
// Define RUN_CTRL_STALL_DETECT_EN to add the stuck-PC detector and the STALLED state.
module cpu_run_controller #(
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 100,
  parameter int CNT_W        = 32,
  parameter int PC_W         = 32,
  parameter int STALL_LIMIT  = 16
) (
  input logic                   clk,
  input logic                   reset,
  cpu_run_controller_if.master  bus
);

  localparam int               HOLD_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(MAX_CYCLES);
  localparam bit                LIMIT_EN  = (MAX_CYCLES != 0);

  typedef enum logic [2:0] {
    ST_RESET_HOLD,
    ST_RUN,
    ST_HALTED,
    ST_TIMEOUT
`ifdef RUN_CTRL_STALL_DETECT_EN
    , ST_STALLED
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]   count_q, count_d, count_inc;
  logic               cpu_reset_n_q, running_q, done_q, timeout_q;

  // Saturates so an unlimited run never wraps back to zero.
  assign count_inc = (&count_q) ? count_q : count_q + 1'b1;

`ifdef RUN_CTRL_STALL_DETECT_EN
  localparam int                STALL_W    = $clog2(STALL_LIMIT + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT);

  logic [PC_W-1:0]    pc_q;
  logic [STALL_W-1:0] stall_q, stall_d, stall_inc;
  logic               stall_hit;
  logic               stalled_q;

  assign stall_inc = (bus.cpu_pc == pc_q) ? stall_q + 1'b1 : '0;
  assign stall_hit = (stall_inc == STALL_LAST);
  // Counting only continues while the run continues; any other transition clears it.
  assign stall_d   = (state_q == ST_RUN && state_d == ST_RUN) ? stall_inc : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= '0;
      stall_q   <= '0;
      stalled_q <= 1'b0;
    end else begin
      pc_q      <= bus.cpu_pc;
      stall_q   <= stall_d;
      stalled_q <= (state_d == ST_STALLED);
    end
  end

  assign bus.stalled = stalled_q;
`else
  logic unused_pc;
  assign unused_pc   = ^bus.cpu_pc;
  assign bus.stalled = 1'b0;
`endif

  // NOTE: every variable written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    count_d = count_q;
    unique case (state_q)
      ST_RESET_HOLD: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HOLD_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        count_d = count_inc;
        if (bus.start) begin
          state_d = ST_RESET_HOLD;
          hold_d  = '0;
          count_d = '0;
        end else if (bus.cpu_halt) begin
          state_d = ST_HALTED;
        end else if (LIMIT_EN && count_inc == CNT_LIMIT) begin
          state_d = ST_TIMEOUT;
`ifdef RUN_CTRL_STALL_DETECT_EN
        end else if (stall_hit) begin
          state_d = ST_STALLED;
`endif
        end
      end
      default: begin
        if (bus.start) begin
          state_d = ST_RESET_HOLD;
          hold_d  = '0;
          count_d = '0;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RESET_HOLD;
      hold_q        <= '0;
      count_q       <= '0;
      cpu_reset_n_q <= 1'b0;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      count_q       <= count_d;
      cpu_reset_n_q <= (state_d == ST_RUN);
      running_q     <= (state_d == ST_RUN);
      done_q        <= (state_d != ST_RUN) && (state_d != ST_RESET_HOLD);
      timeout_q     <= (state_d == ST_TIMEOUT);
    end
  end

  assign bus.cpu_reset_n = cpu_reset_n_q;
  assign bus.running     = running_q;
  assign bus.done        = done_q;
  assign bus.timeout     = timeout_q;
  assign bus.cycle_count = count_q;

endmodule

// File: doc/cpu_run_controller.md
# cpu_run_controller

Synthesizable run controller wrapped around the MIYAJIRO CPU core in simulation and FPGA bring-up. It sequences the core's reset, counts execution cycles, and stops the run on halt, on a programmable cycle limit, or optionally on a stuck program counter. It reports status so that benches and on-board logic share one run policy.

## Interface
Parameters:
- RESET_CYCLES, default 2: clock periods `cpu_reset_n` is held low per run; must be ≥1.
- MAX_CYCLES, default 100: run-cycle limit; 0 = unlimited.
- CNT_W, default 32: width of `cycle_count`.
- PC_W, default 32: width of `cpu_pc`.
- STALL_LIMIT, default 16: consecutive unchanged-PC cycles that flag a stall; must be ≥2.

Ports:
- clk, input, 1: single clock; all logic on rising edge.
- reset, input, 1: asynchronous, active-high reset of the whole block.
- start, input, 1: single-cycle restart request.
- cpu_halt, input, 1: core halt indication, sampled on rising edge.
- cpu_pc, input, PC_W: core program counter.
- cpu_reset_n, output, 1: active-low reset to the core, registered.
- running, output, 1: high in RUN.
- done, output, 1: high in any terminal state.
- timeout, output, 1: run ended on cycle limit.
- stalled, output, 1: run ended on PC stall.
- cycle_count, output, CNT_W: RUN cycles elapsed in the current or last run.

## Operation
- States: RESET_HOLD, RUN, HALTED, TIMEOUT, STALLED. STALLED exists only with the macro.
- Reset values: state RESET_HOLD, hold counter 0, `cpu_reset_n`=0, `running`=0, `done`=0, `timeout`=0, `stalled`=0, `cycle_count`=0, stall counter 0.
- RESET_HOLD:
  - Hold counter increments each cycle.
  - On the edge where the hold counter equals RESET_CYCLES-1: go to RUN and set `cpu_reset_n`=1.
  - `start` is ignored in this state.
- RUN:
  - Every RUN cycle increments `cycle_count`, including the terminating cycle.
  - `cpu_halt`=1 → HALTED.
  - Otherwise, if MAX_CYCLES≠0 and the incremented count equals MAX_CYCLES → TIMEOUT.
  - Otherwise, a stall → STALLED (macro only).
  - Priority: halt > timeout > stall. A halt on the limit cycle ends in HALTED with `timeout`=0.
- Terminal states (HALTED, TIMEOUT, STALLED):
  - `cpu_reset_n`=0 to freeze the core.
  - `done`=1 and the matching flag is 1.
  - `cycle_count` holds.
- `start` in RUN or any terminal state → RESET_HOLD next cycle. This clears `cycle_count`, the flags, the hold counter and the stall counter, and drives `cpu_reset_n`=0.
- With MAX_CYCLES=0, `cycle_count` saturates at all-ones and never wraps.
- All outputs are registered and decoded from the next state, so no output glitches.

## Timing
- `cpu_reset_n` is low for exactly RESET_CYCLES rising edges after `reset` deasserts or after `start` is accepted.
- Latency is one cycle from the sampled `cpu_halt`, limit, or stall condition to `done`=1 and `running`=0.
- `start` takes effect on the next edge. A `start` and `cpu_halt` in the same RUN cycle: `start` wins and the run restarts.
- `reset` asserted mid-run forces the reset values immediately, without waiting for a clock edge.

## Configuration
- RUN_CTRL_STALL_DETECT_EN defined:
  - A PC register samples `cpu_pc` every cycle.
  - In RUN, the stall counter increments when `cpu_pc` equals the previous sample and clears otherwise. It is cleared outside RUN.
  - Reaching STALL_LIMIT consecutive equal samples → STALLED, `stalled`=1.
- Undefined: the stall logic and STALLED state are absent, `stalled` is tied 0, and `cpu_pc` is ignored. The port list is unchanged.

## Test plan
- Defaults, `reset` released, `cpu_halt` held 0 → `cpu_reset_n` rises exactly 2 edges after release; TIMEOUT with `cycle_count`=100, `done`=1, `timeout`=1, `cpu_reset_n`=0.
- Pulse `cpu_halt` on the 37th RUN cycle → HALTED, `cycle_count`=37, `timeout`=0, `done`=1 on the next cycle.
- Assert `cpu_halt` on the 100th RUN cycle → HALTED, `timeout`=0, `cycle_count`=100.
- After TIMEOUT, pulse `start` → `cycle_count`=0, `done`=0, `cpu_reset_n` low for 2 cycles, then RUN restarts from count 1.
- Macro on, STALL_LIMIT=16, `cpu_pc` frozen at 0x40 from RUN cycle 10 → STALLED with `stalled`=1; MAX_CYCLES=0 with no halt → count never wraps.
- Assert `reset` asynchronously mid-RUN at count 50 → all outputs return to reset values before the next edge; after release, the normal 2-cycle hold and run follow.
